fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/rv32_pkg.sv | 24 ++
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl_fsm.sv | 61 ++++++
 rtl/fetch_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared fetch-stage definitions: datapath width, PC step and fetch FSM encodings.
package rv32_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t PC_INC = addr_t'(4);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        STALL = 2'b10
    } fetch_state_e;

    function automatic addr_t align_word(input addr_t a);
        return a & ~addr_t'(3);
    endfunction

    function automatic logic misaligned(input addr_t a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction memory handshake, redirect input and instruction output.
interface fetch_ctrl_if;
    import rv32_pkg::*;

    logic  imem_req;
    addr_t imem_addr;
    logic  imem_ack;
    logic  stall;
    logic  redirect_valid;
    addr_t redirect_pc;
    logic  inst_valid;
    addr_t inst_pc;
    addr_t pc_current;
    logic  trap_valid;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_pc, pc_current, trap_valid,
        input  imem_ack, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_pc, pc_current, trap_valid,
        output imem_ack, stall, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_ctrl_fsm.sv
// Fetch sequencing FSM: decides when a request is live and when an ack is accepted.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request, acks ignored
// FETCH | request driven at the current PC, waiting for ack
// STALL | downstream busy, request dropped, PC held
module fetch_fsm
    import rv32_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic imem_ack,
    input  logic stall,
    input  logic redirect_valid,
    output logic imem_req,
    output logic accept
);

    fetch_state_e state;
    fetch_state_e state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        accept    = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    accept    = 1'b1;
                    state_nxt = stall ? STALL : FETCH;
                end
            end
            STALL: begin
                if (!stall) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
        // A redirect wins everywhere and discards any ack seen in the same cycle.
        if (redirect_valid) begin
            state_nxt = FETCH;
            accept    = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC, instruction output and redirect handling.
// Define FETCH_CTRL_MISALIGN_TRAP_EN to send misaligned redirects to TRAP_VEC with a trap pulse.
module fetch_ctrl
    import rv32_pkg::*;
#(
    parameter addr_t RESET_VEC = 32'h0000_0000,
    parameter addr_t TRAP_VEC  = 32'h0000_0100
) (
    input  logic clk,
    input  logic rst_n,
    fetch_ctrl_if.master bus
);

    logic  imem_req;
    logic  accept;
    addr_t pc_q;
    addr_t pc_nxt;
    addr_t redirect_tgt;
    logic  inst_valid_q;
    addr_t inst_pc_q;

    fetch_fsm u_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_ack       (bus.imem_ack),
        .stall          (bus.stall),
        .redirect_valid (bus.redirect_valid),
        .imem_req       (imem_req),
        .accept         (accept)
    );

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic trap_q;
    logic redirect_misaligned;

    assign redirect_misaligned = misaligned(bus.redirect_pc);
    assign redirect_tgt = redirect_misaligned ? TRAP_VEC : align_word(bus.redirect_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= bus.redirect_valid & redirect_misaligned;
        end
    end

    assign bus.trap_valid = trap_q;
`else
    assign redirect_tgt   = align_word(bus.redirect_pc);
    assign bus.trap_valid = 1'b0;
`endif

    always_comb begin
        pc_nxt = pc_q;
        if (bus.redirect_valid) begin
            pc_nxt = redirect_tgt;
        end else if (accept) begin
            pc_nxt = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VEC;
            inst_valid_q <= 1'b0;
            inst_pc_q    <= '0;
        end else begin
            pc_q         <= pc_nxt;
            inst_valid_q <= accept;
            if (accept) begin
                inst_pc_q <= pc_q;
            end
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.imem_addr  = pc_q;
    assign bus.pc_current = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_pc    = inst_pc_q;

endmodule
